// File: rtl/simon_seq_ctrl.sv
// rtl/simon_seq_ctrl.sv - Simon game sequencer: sequence memory, playback, press capture and compare control
// Optional feature macro: SIMON_TIMEOUT_EN (lose after TIMEOUT_CYCLES WAIT_IN cycles without a press).
module simon_seq_ctrl #(
  parameter int MAX_LEN        = 16,
  parameter int LEN_W          = 5,
  parameter int FLASH_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       rnd_colour,
  input  logic             btn_valid,
  input  logic [1:0]       btn_colour,
  input  logic [1:0]       cmp_out,
  output logic             cmp_enable,
  output logic [1:0]       cmp_expected,
  output logic [1:0]       cmp_player,
  output logic             show_valid,
  output logic [1:0]       show_colour,
  output logic [LEN_W-1:0] round_len,
  output logic             busy,
  output logic             win,
  output logic             lose
);

  // Address width of the sequence memory; at least one bit so tiny games still elaborate.
  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int FC_W   = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;

  localparam logic [1:0] RES_MATCH = 2'b01;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADD,
    S_SHOW,
    S_GAP,
    S_WAIT_IN,
    S_CMP,
    S_CHK,
    S_WIN,
    S_LOSE
  } state_t;

  state_t            state;
  logic [LEN_W-1:0]  idx;
  logic [FC_W-1:0]   flash_cnt;
  logic [1:0]        mem [DEPTH];

  logic [LEN_W-1:0]  idx_inc;
  logic              idx_is_last;
  logic              len_is_max;
  logic              flash_done;

`ifdef SIMON_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              tmo_hit;
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

  assign idx_inc     = idx + LEN_W'(1);
  assign idx_is_last = (idx == round_len - LEN_W'(1));
  assign len_is_max  = (round_len == LEN_W'(MAX_LEN));
  assign flash_done  = (flash_cnt == FC_W'(FLASH_CYCLES - 1));

  // Sequence memory: one new random colour is appended in each ADD cycle.
  always_ff @(posedge clk) begin
    if (resetn && state == S_ADD) begin
      mem[round_len[ADDR_W-1:0]] <= rnd_colour;
    end
  end

  // Game FSM; every output is registered and set on the transition into the state that owns it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= S_IDLE;
      round_len    <= '0;
      idx          <= '0;
      flash_cnt    <= '0;
      cmp_enable   <= 1'b0;
      cmp_expected <= 2'b00;
      cmp_player   <= 2'b00;
      show_valid   <= 1'b0;
      show_colour  <= 2'b00;
      busy         <= 1'b0;
      win          <= 1'b0;
      lose         <= 1'b0;
`ifdef SIMON_TIMEOUT_EN
      tmo_cnt      <= '0;
`endif
    end else begin
      // The comparator enable is a single-cycle strobe owned by CMP.
      cmp_enable <= 1'b0;
      case (state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (start) begin
            round_len <= '0;
            busy      <= 1'b1;
            win       <= 1'b0;
            lose      <= 1'b0;
            state     <= S_ADD;
          end
        end

        S_ADD: begin
          round_len   <= round_len + LEN_W'(1);
          idx         <= '0;
          flash_cnt   <= '0;
          show_valid  <= 1'b1;
          // On the first round entry 0 is being written this very cycle, so bypass the memory.
          show_colour <= (round_len == '0) ? rnd_colour : mem[0];
          state       <= S_SHOW;
        end

        S_SHOW: begin
          if (flash_done) begin
            show_valid  <= 1'b0;
            show_colour <= 2'b00;
            state       <= S_GAP;
          end else begin
            flash_cnt <= flash_cnt + FC_W'(1);
          end
        end

        S_GAP: begin
          if (idx_is_last) begin
            idx   <= '0;
`ifdef SIMON_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
            state <= S_WAIT_IN;
          end else begin
            idx         <= idx_inc;
            flash_cnt   <= '0;
            show_valid  <= 1'b1;
            show_colour <= mem[idx_inc[ADDR_W-1:0]];
            state       <= S_SHOW;
          end
        end

        S_WAIT_IN: begin
          if (btn_valid) begin
            cmp_player   <= btn_colour;
            cmp_expected <= mem[idx[ADDR_W-1:0]];
            cmp_enable   <= 1'b1;
            state        <= S_CMP;
`ifdef SIMON_TIMEOUT_EN
          end else if (tmo_hit) begin
            busy  <= 1'b0;
            lose  <= 1'b1;
            state <= S_LOSE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
`endif
          end
        end

        // The comparator registers its result at the end of this cycle; cmp_out is not read here.
        S_CMP: begin
          state <= S_CHK;
        end

        S_CHK: begin
          if (cmp_out == RES_MATCH) begin
            if (!idx_is_last) begin
              idx   <= idx_inc;
`ifdef SIMON_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
              state <= S_WAIT_IN;
            end else if (len_is_max) begin
              busy  <= 1'b0;
              win   <= 1'b1;
              state <= S_WIN;
            end else begin
              state <= S_ADD;
            end
          end else begin
            busy  <= 1'b0;
            lose  <= 1'b1;
            state <= S_LOSE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// tb/tb_simon_seq_ctrl.sv - randomized self-checking bench for simon_seq_ctrl against a game-level model
module tb_simon_seq_ctrl;

  localparam int MAXL = 4;
  localparam int LW   = 5;
  localparam int FL   = 4;
  localparam int TO   = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [1:0]    rnd_colour;
  logic          btn_valid;
  logic [1:0]    btn_colour;
  logic [1:0]    cmp_out;
  logic          cmp_enable;
  logic [1:0]    cmp_expected;
  logic [1:0]    cmp_player;
  logic          show_valid;
  logic [1:0]    show_colour;
  logic [LW-1:0] round_len;
  logic          busy;
  logic          win;
  logic          lose;

  simon_seq_ctrl #(
    .MAX_LEN(MAXL), .LEN_W(LW), .FLASH_CYCLES(FL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .rnd_colour(rnd_colour),
    .btn_valid(btn_valid), .btn_colour(btn_colour), .cmp_out(cmp_out),
    .cmp_enable(cmp_enable), .cmp_expected(cmp_expected), .cmp_player(cmp_player),
    .show_valid(show_valid), .show_colour(show_colour), .round_len(round_len),
    .busy(busy), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Expected outputs for the current cycle, written by the game model.
  bit         e_sv, e_ce, e_b, e_w, e_l, e_all0;
  logic [1:0] e_sc, e_cx, e_cp;
  int         m_len;
  logic [1:0] seq [$];
  logic [1:0] dir_cols [$];
  logic [1:0] dir_press [$];
  bit         lit_first = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input bit sv, input logic [1:0] sc, input bit ce, input logic [1:0] cx,
                    input logic [1:0] cp, input bit b, input bit w, input bit l);
    e_sv = sv; e_sc = sc; e_ce = ce; e_cx = cx; e_cp = cp;
    e_b = b; e_w = w; e_l = l; e_all0 = 1'b0;
  endtask

  task automatic noise(input bit busy_st);
    start      = busy_st ? ($urandom_range(0, 3) == 0) : 1'b0;
    btn_valid  = ($urandom_range(0, 3) == 0);
    btn_colour = 2'($urandom_range(0, 3));
    cmp_out    = 2'($urandom_range(0, 3));
    rnd_colour = 2'($urandom_range(0, 3));
  endtask

  task automatic linger(input int n);
    for (int k = 0; k < n; k++) begin
      noise(1'b0);
      tick();
    end
  endtask

  // Compare process: every cycle once reset has been applied.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("show_valid", 8'(show_valid), 8'(e_sv));
      if (e_sv || e_all0) chk("show_colour", 8'(show_colour), 8'(e_sc));
      chk("cmp_enable", 8'(cmp_enable), 8'(e_ce));
      if (e_ce || e_all0) begin
        chk("cmp_expected", 8'(cmp_expected), 8'(e_cx));
        chk("cmp_player", 8'(cmp_player), 8'(e_cp));
      end
      chk("round_len", 8'(round_len), 8'(m_len));
      chk("busy", 8'(busy), 8'(e_b));
      chk("win", 8'(win), 8'(e_w));
      chk("lose", 8'(lose), 8'(e_l));
    end
  end

  // One game from start to WIN/LOSE (or to a mid-playback reset).
  task automatic play_game(input int err_pct, input int ab_round, input int ab_i, input int ab_f);
    logic [1:0] c, p, resp;
    int d;
    noise(1'b0);
    start = 1'b1;
    tick();
    seq.delete();
    m_len = 0;
    forever begin
      noise(1'b1);
      if (dir_cols.size() > 0) c = dir_cols.pop_front();
      else c = 2'($urandom_range(0, 3));
      rnd_colour = c;
      ex(0, 0, 0, 0, 0, 1, 0, 0);
      tick();
      seq.push_back(c);
      m_len++;
      for (int i = 0; i < m_len; i++) begin
        for (int f = 0; f <= FL; f++) begin
          noise(1'b1);
          if (f < FL) ex(1, seq[i], 0, 0, 0, 1, 0, 0);
          else        ex(0, 0, 0, 0, 0, 1, 0, 0);
          if (lit_first && m_len == 1 && f == 0) begin
            chk("lit_first_colour", 8'(show_colour), 8'h2);
            chk("lit_first_len", 8'(round_len), 8'h1);
            lit_first = 1'b0;
          end
          if (m_len == ab_round && i == ab_i && f == ab_f) begin
            resetn = 1'b0;
            tick();
            resetn = 1'b1;
            m_len = 0;
            ex(0, 0, 0, 0, 0, 0, 0, 0);
            e_all0 = 1'b1;
            return;
          end
          tick();
        end
      end
      for (int i = 0; i < m_len; i++) begin
`ifdef SIMON_TIMEOUT_EN
        d = (err_pct > 0 && $urandom_range(0, 9) == 0) ? TO : $urandom_range(0, TO - 1);
`else
        d = $urandom_range(0, 4);
`endif
        for (int w = 0; w < d; w++) begin
          noise(1'b1);
          btn_valid = 1'b0;
          ex(0, 0, 0, 0, 0, 1, 0, 0);
          tick();
        end
`ifdef SIMON_TIMEOUT_EN
        if (d == TO) begin
          ex(0, 0, 0, 0, 0, 0, 0, 1);
          return;
        end
`endif
        noise(1'b1);
        if (dir_press.size() > 0) p = dir_press.pop_front();
        else if ($urandom_range(0, 99) < err_pct) p = seq[i] + 2'($urandom_range(1, 3));
        else p = seq[i];
        btn_valid  = 1'b1;
        btn_colour = p;
        ex(0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        noise(1'b1);
        ex(0, 0, 1, seq[i], p, 1, 0, 0);
        tick();
        noise(1'b1);
        resp = (p == seq[i]) ? 2'b01 : 2'b10;
        if (err_pct > 0 && $urandom_range(0, 99) < 5) resp = 2'b00;
        cmp_out = resp;
        ex(0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        if (resp != 2'b01) begin
          ex(0, 0, 0, 0, 0, 0, 0, 1);
          return;
        end
      end
      if (m_len == MAXL) begin
        ex(0, 0, 0, 0, 0, 0, 1, 0);
        return;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int err, ab_round, ab_i;
    resetn = 1'b0; start = 1'b0; rnd_colour = 2'b00;
    btn_valid = 1'b0; btn_colour = 2'b00; cmp_out = 2'b00;
    tick();
    tick();
    resetn = 1'b1;
    m_len = 0;
    ex(0, 0, 0, 0, 0, 0, 0, 0);
    e_all0 = 1'b1;
    chk_en = 1'b1;
    chk("lit_reset_busy", 8'(busy), 8'h0);
    chk("lit_reset_len", 8'(round_len), 8'h0);
    linger(6);

    dir_cols  = '{2'b10, 2'b01};
    dir_press = '{2'b10, 2'b10, 2'b11};
    lit_first = 1'b1;
    play_game(0, 0, 0, 0);
    chk("lit_lose", 8'(lose), 8'h1);
    chk("lit_lose_len", 8'(round_len), 8'h2);
    linger(3);

    dir_cols  = '{2'b10};
    lit_first = 1'b1;
    play_game(0, 0, 0, 0);
    chk("lit_win", 8'(win), 8'h1);
    chk("lit_win_busy", 8'(busy), 8'h0);
    chk("lit_win_len", 8'(round_len), 8'h4);
    linger(2);

    play_game(0, 3, $urandom_range(0, 2), $urandom_range(0, FL));
    chk("lit_abort_show", 8'(show_valid), 8'h0);
    chk("lit_abort_len", 8'(round_len), 8'h0);
    linger(2);

    for (int g = 0; g < 30; g++) begin
      err      = ($urandom_range(0, 1) == 1) ? 15 : 0;
      ab_round = ($urandom_range(0, 4) == 0) ? $urandom_range(1, MAXL) : 0;
      ab_i     = (ab_round > 0) ? $urandom_range(0, ab_round - 1) : 0;
      play_game(err, ab_round, ab_i, $urandom_range(0, FL));
      linger($urandom_range(1, 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simon_seq_ctrl.md
# simon_seq_ctrl

Game sequencer for the Simon datapath. It owns the colour-sequence memory and grows the sequence by one entry per round. It plays the sequence back to the display, collects player button presses, and drives the registered colour comparator one press at a time. It decides continue, next round, win or lose from the comparator's 2-bit result (01 match, 10 mismatch).

## Interface
- MAX_LEN, 16, maximum sequence length; reaching it with all entries correct is a win.
- LEN_W, 5, width of length/index counters; MAX_LEN < 2**LEN_W.
- FLASH_CYCLES, 4, cycles each colour is shown during playback (>= 1).
- TIMEOUT_CYCLES, 1000, player-input timeout (used only with SIMON_TIMEOUT_EN).
- clk  in  1  system clock, all state changes on posedge.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  begin a new game; honoured only in IDLE, WIN or LOSE.
- rnd_colour  in  2  free-running random colour, sampled in ADD.
- btn_valid  in  1  one-cycle pulse: player pressed a button.
- btn_colour  in  2  colour of the press, valid with btn_valid.
- cmp_out  in  2  comparator result (01 match, 10 mismatch, 00 reset/none).
- cmp_enable  out  1  comparator enable, high only in CMP.
- cmp_expected  out  2  stored colour at current index (comparator `compare`).
- cmp_player  out  2  captured player colour (comparator `in`).
- show_valid  out  1  display lamp on.
- show_colour  out  2  colour to display, valid with show_valid.
- round_len  out  LEN_W  current sequence length.
- busy  out  1  high in every state except IDLE, WIN, LOSE.
- win, lose  out  1  held high in WIN / LOSE respectively.

## Operation
- States: IDLE, ADD, SHOW, GAP, WAIT_IN, CMP, CHK, WIN, LOSE.
- Reset: state IDLE, round_len 0, idx 0, counters 0. All outputs 0 (cmp_expected/cmp_player 2'b00). Memory contents need not be cleared.
- IDLE/WIN/LOSE + start: round_len <= 0, go to ADD.
- ADD (1 cycle): mem[round_len] <= rnd_colour; round_len++; idx <= 0; go to SHOW.
- SHOW: show_valid=1, show_colour=mem[idx] for FLASH_CYCLES cycles, then go to GAP.
- GAP (1 cycle, show_valid=0):
  - if idx == round_len-1, idx <= 0 and go to WAIT_IN;
  - otherwise idx++ and go to SHOW.
- WAIT_IN: on btn_valid, capture btn_colour into the player register and go to CMP. Presses in any other state are ignored.
- CMP (1 cycle): cmp_enable=1 with cmp_expected=mem[idx] and cmp_player=captured colour. Go to CHK.
- CHK: evaluate cmp_out.
  - 01 and idx < round_len-1: idx++, go to WAIT_IN.
  - 01 and idx == round_len-1: go to WIN if round_len == MAX_LEN, else ADD.
  - 10 or 00: go to LOSE.
- WIN/LOSE: sticky until start or reset; round_len holds the final length.
- start outside IDLE/WIN/LOSE is ignored.
- Reset asserted in any state returns to the reset values on the next edge; any in-progress playback or compare is abandoned.

## Timing
- Press latency: btn_valid sampled at edge t (WAIT_IN) → CMP during cycle t..t+1 → comparator registers at t+1 → CHK during t+1..t+2 → next state at edge t+2.
- Result is never read in the CMP cycle itself; the comparator's stale output is irrelevant.
- Playback of length L takes L*(FLASH_CYCLES+1) cycles; the first flash starts the cycle after ADD.
- Back-to-back presses: a press arriving in CMP or CHK is dropped. Only one outstanding compare exists at a time.
- cmp_expected/cmp_player are stable throughout CMP.

## Configuration
- SIMON_TIMEOUT_EN defined: a counter clears on WAIT_IN entry and increments each WAIT_IN cycle. Reaching TIMEOUT_CYCLES with no btn_valid goes to LOSE. A btn_valid arriving in the same cycle the count reaches TIMEOUT_CYCLES wins (the press is taken).
- SIMON_TIMEOUT_EN undefined: no counter; WAIT_IN waits indefinitely. TIMEOUT_CYCLES is unused.

## Test plan
- Reset then idle: all outputs 0, state IDLE; btn_valid pulses → no cmp_enable.
- start with rnd_colour=2'b10: round_len=1; show_valid high 4 cycles with colour 10, then 1 low cycle; press 10 with cmp_out returning 01 → ADD, round_len=2.
- Round 2 with sequence {10,01}: press 10 then 11, comparator returns 01 then 10 → lose=1, round_len stays 2; start → round_len=1.
- MAX_LEN=2, all presses correct → win=1 after the second round's final CHK, busy=0.
- Reset asserted mid-SHOW (round 3) → next cycle IDLE, show_valid=0, round_len=0.
- With SIMON_TIMEOUT_EN and TIMEOUT_CYCLES=8: no press for 8 WAIT_IN cycles → lose=1. A press at cycle 7 → CMP taken normally.
